inst_feeder: RTL and testbench
==============================

INST_FEEDER -- requirements
Module: inst_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the instruction FIFO depth (power of two, >= 2).
REQ-002 SHALL have parameter FLUSH_N, default 4, the number of NOP words issued during drain.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000000, the instruction word driven when no instruction is issued.
REQ-004 SHALL have port cpu_clk_50M  input  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port cpu_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin issuing instructions.
REQ-007 SHALL have port stop  input  1  one-cycle request to finish issuing, flush, and return to idle.
REQ-008 SHALL have port in_valid  input  1  host instruction word valid.
REQ-009 SHALL have port in_inst  input  32  host instruction word.
REQ-010 SHALL have port in_ready  output  1  FIFO can accept a word.
REQ-011 SHALL have port en  output  1  CPU enable; high in every cycle an instruction or flush NOP is presented.
REQ-012 SHALL have port outer_inst  output  32  instruction word presented to the CPU.
REQ-013 SHALL have ports peek1 and peek2  input  32 each  CPU debug observation words.
REQ-014 SHALL have port snap_req  input  1  request to capture peek1 and peek2.
REQ-015 SHALL have ports snap1 and snap2  output  32 each  captured peek values.
REQ-016 SHALL have port snap_valid  output  1  one-cycle pulse marking fresh snap1 and snap2 values.
REQ-017 SHALL have port issued_cnt  output  16  count of FIFO words issued.
REQ-018 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 SHALL implement the states IDLE, RUN and DRAIN.
REQ-020 SHALL transition IDLE->RUN when start=1; in IDLE, stop SHALL be ignored, and start+stop together SHALL enter RUN.
REQ-021 SHALL, in RUN, transition to DRAIN when stop=1; start SHALL be ignored in RUN and in DRAIN.
REQ-022 SHALL, in DRAIN, first issue all remaining FIFO words, then issue FLUSH_N NOP_WORD cycles with en=1, then enter IDLE.
REQ-023 SHALL, in RUN or in the FIFO-emptying phase of DRAIN with the FIFO non-empty, pop one word per cycle and register it as outer_inst with en=1 on the same edge.
REQ-024 SHALL, when the FIFO is empty in RUN, or in any cycle in IDLE, register en=0 and outer_inst=NOP_WORD.
REQ-025 SHALL give a word accepted (in_valid & in_ready) at edge k, with RUN active and the FIFO otherwise empty, en=1 and outer_inst=word after edge k+1.
REQ-026 SHALL drive in_ready = !full; a push while full SHALL be refused even if a pop occurs in the same cycle.
REQ-027 SHALL perform a push and a pop in the same cycle when not full and not empty, leaving occupancy unchanged.
REQ-028 SHALL issue words in exact arrival order, with no loss or duplication, across pointer wrap-around.
REQ-029 SHALL accept pushes in every state, including IDLE and DRAIN.
REQ-030 SHALL increment issued_cnt once per popped word (never for NOPs), wrapping from 16'hFFFF to 0.
REQ-031 SHALL, on snap_req=1 at edge k, load snap1 and snap2 with peek1 and peek2 sampled at edge k and set snap_valid=1 for the cycle after edge k.
REQ-032 SHALL treat back-to-back snap_req as independent captures, each producing its own snap_valid pulse.
REQ-033 SHALL drive busy combinationally from the state.

Reset
REQ-034 SHALL, while cpu_rst=1, immediately and independently of the clock force: state=IDLE; FIFO empty; en=0; outer_inst=NOP_WORD; snap1=snap2=0; snap_valid=0; issued_cnt=0; in_ready=0.
REQ-035 SHALL, on the first edge after cpu_rst falls, have in_ready=1.
REQ-036 SHALL discard FIFO contents and any in-progress flush on a reset asserted mid-RUN or mid-DRAIN, with no further en pulses.

Verification
REQ-037 SHALL be verified by: push 3 words A, B, C in IDLE, then start -> en=1 for exactly 3 consecutive cycles with outer_inst A, B, C; issued_cnt=3; en=0 afterwards.
REQ-038 SHALL be verified by: push DEPTH words with no start -> in_ready=0; then start, and push X in the first pop cycle -> X refused; X accepted on the next cycle and issued last.
REQ-039 SHALL be verified by: RUN with 2 words queued, then stop -> 2 words issued, then 4 cycles with en=1 and outer_inst=0, then busy=0 and en=0.
REQ-040 SHALL be verified by: snap_req with peek1=32'h12345678 and peek2=32'hDEADBEEF -> after the next edge snap1/snap2 equal those values and snap_valid is high for exactly 1 cycle.
REQ-041 SHALL be verified by: issue 20 words through DEPTH=8 with random in_valid -> order preserved across wrap; issued_cnt=20.
REQ-042 SHALL be verified by: assert cpu_rst mid-DRAIN between clock edges -> en=0 and busy=0 immediately, and in_ready=1 one edge after release.

Source files
------------

// File: rtl/inst_feeder.sv
// Instruction feeder: buffers host instruction words in a FIFO and issues them to the CPU
// one per cycle, flushing with NOP words on stop; also captures CPU debug words on request.
module inst_feeder #(
   parameter int          DEPTH    = 8,
   parameter int          FLUSH_N  = 4,
   parameter logic [31:0] NOP_WORD = 32'h00000000
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        start,
   input  logic        stop,
   input  logic        in_valid,
   input  logic [31:0] in_inst,
   output logic        in_ready,
   output logic        en,
   output logic [31:0] outer_inst,
   input  logic [31:0] peek1,
   input  logic [31:0] peek2,
   input  logic        snap_req,
   output logic [31:0] snap1,
   output logic [31:0] snap2,
   output logic        snap_valid,
   output logic [15:0] issued_cnt,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int FW = $clog2(FLUSH_N + 2);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   // Handshake: a word transfers on a rising edge where in_valid && in_ready were both high.
   state_t         state_q, state_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic           en_q, en_d;
   logic [31:0]    outer_q, outer_d;
   logic           flushing_q, flushing_d;
   logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
   logic [15:0]    issued_q, issued_d;
   logic [31:0]    snap1_q, snap1_d, snap2_q, snap2_d;
   logic           snap_valid_q, snap_valid_d;
   logic           init_q, init_d;
   logic [31:0]    mem_q [DEPTH];

   logic empty, full, push, pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // init_q keeps in_ready low until the first edge after reset release.
   assign in_ready = init_q & ~full;
   assign push     = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      en_d        = 1'b0;
      outer_d     = NOP_WORD;
      pop         = 1'b0;
      flushing_d  = flushing_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            pop = ~empty;
            if (stop) state_d = DRAIN;
         end
         DRAIN: begin
            if (!flushing_q && !empty) begin
               pop = 1'b1;
            end else if (flush_cnt_q < FW'(FLUSH_N)) begin
               en_d        = 1'b1;
               flushing_d  = 1'b1;
               flush_cnt_d = flush_cnt_q + 1'b1;
            end else begin
               state_d     = IDLE;
               flushing_d  = 1'b0;
               flush_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         en_d    = 1'b1;
         outer_d = mem_q[rd_ptr_q[AW-1:0]];
      end
      wr_ptr_d     = wr_ptr_q + PW'(push);
      rd_ptr_d     = rd_ptr_q + PW'(pop);
      issued_d     = issued_q + 16'(pop);
      snap1_d      = snap_req ? peek1 : snap1_q;
      snap2_d      = snap_req ? peek2 : snap2_q;
      snap_valid_d = snap_req;
      init_d       = 1'b1;
   end

   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         en_q         <= 1'b0;
         outer_q      <= NOP_WORD;
         flushing_q   <= 1'b0;
         flush_cnt_q  <= '0;
         issued_q     <= '0;
         snap1_q      <= '0;
         snap2_q      <= '0;
         snap_valid_q <= 1'b0;
         init_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         en_q         <= en_d;
         outer_q      <= outer_d;
         flushing_q   <= flushing_d;
         flush_cnt_q  <= flush_cnt_d;
         issued_q     <= issued_d;
         snap1_q      <= snap1_d;
         snap2_q      <= snap2_d;
         snap_valid_q <= snap_valid_d;
         init_q       <= init_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge cpu_clk_50M) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_inst;
   end

   assign en         = en_q;
   assign outer_inst = outer_q;
   assign issued_cnt = issued_q;
   assign snap1      = snap1_q;
   assign snap2      = snap2_q;
   assign snap_valid = snap_valid_q;
   assign busy       = (state_q != IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_feeder.sv
// Self-checking bench for inst_feeder: directed sequences plus a scoreboard that tracks
// every accepted host word and compares it against the issued instruction stream.
module tb_inst_feeder;

   localparam int          DEPTH   = 8;
   localparam int          FLUSH_N = 4;
   localparam logic [31:0] NOP     = 32'h00000000;

   logic        cpu_clk_50M = 1'b0;
   logic        cpu_rst, start, stop, in_valid, snap_req;
   logic [31:0] in_inst, peek1, peek2;
   logic        in_ready, en, snap_valid, busy;
   logic [31:0] outer_inst, snap1, snap2;
   logic [15:0] issued_cnt;
   logic [1:0]  dbg_state;

   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          nop_seen = 0;
   int          issued_model = 0;
   logic [31:0] last_issued = '0;

   always #10 cpu_clk_50M = ~cpu_clk_50M;

   inst_feeder #(.DEPTH(DEPTH), .FLUSH_N(FLUSH_N), .NOP_WORD(NOP)) dut (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .start(start), .stop(stop),
      .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready), .en(en),
      .outer_inst(outer_inst), .peek1(peek1), .peek2(peek2), .snap_req(snap_req),
      .snap1(snap1), .snap2(snap2), .snap_valid(snap_valid), .issued_cnt(issued_cnt),
      .busy(busy), .dbg_state(dbg_state)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare issued words first, then record the word accepted at the coming edge.
   always @(negedge cpu_clk_50M) begin
      if (!cpu_rst) begin
         if (en) begin
            if (exp_q.size() > 0) begin
               check_val("inst_order", outer_inst, exp_q.pop_front());
               issued_model++;
               last_issued = outer_inst;
            end else begin
               check_val("nop_word", outer_inst, NOP);
               nop_seen++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(in_inst);
      end
   end

   task automatic tick();
      @(posedge cpu_clk_50M);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      in_valid = 1'b1;
      in_inst  = w;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++) tick();
      check_val("drain_done", {31'b0, busy}, 32'd0);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
      check_val("queue_empty", exp_q.size(), 32'd0);
   endtask

   task automatic do_drain();
      int nop_base;
      nop_base = nop_seen;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle();
      check_val("flush_count", nop_seen - nop_base, FLUSH_N);
      check_val("idle_en", {31'b0, en}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      int nop_base;
      int base;
      int accepted;
      cpu_rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; snap_req = 1'b0;
      in_inst = '0; peek1 = '0; peek2 = '0;

      #5;
      check_val("rst_en", {31'b0, en}, 32'd0);
      check_val("rst_inst", outer_inst, NOP);
      check_val("rst_ready", {31'b0, in_ready}, 32'd0);
      check_val("rst_busy", {31'b0, busy}, 32'd0);
      check_val("rst_issued", {16'b0, issued_cnt}, 32'd0);
      check_val("rst_snap_valid", {31'b0, snap_valid}, 32'd0);
      check_val("rst_snap1", snap1, 32'd0);
      check_val("rst_snap2", snap2, 32'd0);
      tick(); tick();
      @(negedge cpu_clk_50M);
      cpu_rst = 1'b0;
      tick();
      check_val("ready_after_rst", {31'b0, in_ready}, 32'd1);

      // Three words queued in IDLE, then start: exactly three consecutive issues.
      push_word(32'hAAAA_0001);
      push_word(32'hBBBB_0002);
      push_word(32'hCCCC_0003);
      check_val("idle_no_issue", {31'b0, en}, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("run_busy", {31'b0, busy}, 32'd1);
      check_val("en_before_pop", {31'b0, en}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("en_abc", {31'b0, en}, 32'd1);
      end
      tick();
      check_val("en_after_abc", {31'b0, en}, 32'd0);
      check_val("issued_abc", {16'b0, issued_cnt}, 32'd3);
      check_val("nops_in_run", nop_seen, 32'd0);
      do_drain();

      // Two words queued, then start followed by stop: words, four NOPs, idle.
      nop_base = nop_seen;
      push_word(32'hDDDD_0004);
      push_word(32'hEEEE_0005);
      start = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      check_val("drain_w1_en", {31'b0, en}, 32'd1);
      tick();
      check_val("drain_w2_en", {31'b0, en}, 32'd1);
      check_val("drain_w2_inst", outer_inst, 32'hEEEE_0005);
      for (int i = 0; i < FLUSH_N; i++) begin
         tick();
         check_val("flush_en", {31'b0, en}, 32'd1);
         check_val("flush_inst", outer_inst, NOP);
         check_val("flush_busy", {31'b0, busy}, 32'd1);
      end
      tick();
      check_val("post_flush_en", {31'b0, en}, 32'd0);
      check_val("post_flush_busy", {31'b0, busy}, 32'd0);
      check_val("flush_nops", nop_seen - nop_base, FLUSH_N);

      // Fill to DEPTH, start, and offer X while full.
      for (int i = 0; i < DEPTH; i++) push_word(32'hF000_0000 + i);
      check_val("full_ready", {31'b0, in_ready}, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_inst  = 32'h5A5A_5A5A;
      check_val("ready_first_pop", {31'b0, in_ready}, 32'd0);
      tick();
      check_val("ready_after_pop", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      wait_empty();
      tick();
      check_val("x_last", last_issued, 32'h5A5A_5A5A);
      check_val("issued_full", {16'b0, issued_cnt}, 32'(issued_model));
      do_drain();

      // Debug snapshots: single and back-to-back.
      peek1 = 32'h12345678; peek2 = 32'hDEADBEEF; snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      peek1 = 32'h0; peek2 = 32'h0;
      check_val("snap1", snap1, 32'h12345678);
      check_val("snap2", snap2, 32'hDEADBEEF);
      check_val("snap_valid_hi", {31'b0, snap_valid}, 32'd1);
      tick();
      check_val("snap_valid_lo", {31'b0, snap_valid}, 32'd0);
      check_val("snap1_hold", snap1, 32'h12345678);
      peek1 = 32'h1111_0001; peek2 = 32'h2222_0001; snap_req = 1'b1;
      tick();
      check_val("b2b_snap1_a", snap1, 32'h1111_0001);
      check_val("b2b_valid_a", {31'b0, snap_valid}, 32'd1);
      peek1 = 32'h1111_0002; peek2 = 32'h2222_0002;
      tick();
      snap_req = 1'b0;
      check_val("b2b_snap2_b", snap2, 32'h2222_0002);
      check_val("b2b_valid_b", {31'b0, snap_valid}, 32'd1);
      tick();
      check_val("b2b_valid_end", {31'b0, snap_valid}, 32'd0);

      // Twenty random words with random in_valid, crossing pointer wrap.
      base = issued_model;
      start = 1'b1;
      tick();
      start = 1'b0;
      accepted = 0;
      for (int i = 0; i < 2000 && accepted < 20; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_inst  = $urandom;
         if (in_valid && in_ready) accepted++;
         tick();
      end
      in_valid = 1'b0;
      check_val("rand_accepted", accepted, 32'd20);
      wait_empty();
      tick();
      check_val("issued_rand", {16'b0, issued_cnt}, 32'(16'(base + 20)));

      // Reset between edges while flushing.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick(); tick();
      #2;
      cpu_rst = 1'b1;
      #1;
      check_val("mid_rst_en", {31'b0, en}, 32'd0);
      check_val("mid_rst_busy", {31'b0, busy}, 32'd0);
      check_val("mid_rst_ready", {31'b0, in_ready}, 32'd0);
      check_val("mid_rst_issued", {16'b0, issued_cnt}, 32'd0);
      exp_q.delete();
      issued_model = 0;
      nop_base = nop_seen;
      tick();
      @(negedge cpu_clk_50M);
      cpu_rst = 1'b0;
      tick();
      check_val("ready_after_mid_rst", {31'b0, in_ready}, 32'd1);
      check_val("busy_after_mid_rst", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_val("no_en_after_rst", {31'b0, en}, 32'd0);
      end
      check_val("no_nops_after_rst", nop_seen - nop_base, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
